// File: rtl/seq_controller.sv
`default_nettype none
// ============================================================================
// Module   : seq_controller
// Purpose  : Multi-cycle fetch/decode/execute sequencer for the 8-bit datapath
// Revision : 1.0  initial release
// ============================================================================
module seq_controller (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  pc,
  output logic [7:0]  instr_addr,
  input  logic [15:0] instr_data,
  output logic        pc_increment,
  output logic        pc_branch,
  output logic [7:0]  pc_newpc,
  output logic [1:0]  rf_select0,
  input  logic [7:0]  rf_selected0,
  output logic        rf_write,
  output logic [1:0]  rf_wr_select,
  output logic [7:0]  rf_data,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        alu_add_sub,
  output logic        alu_set_low,
  output logic        alu_set_high,
  input  logic [7:0]  alu_result,
  output logic        dly_start,
  output logic        dly_enable,
  output logic [7:0]  dly_value,
  input  logic        dly_done,
  output logic        busy,
  output logic        halted,
  output logic        illegal
);

  localparam logic [3:0] c_ST_IDLE     = 4'd0;
  localparam logic [3:0] c_ST_FETCH    = 4'd1;
  localparam logic [3:0] c_ST_DECODE   = 4'd2;
  localparam logic [3:0] c_ST_READ_A   = 4'd3;
  localparam logic [3:0] c_ST_READ_B   = 4'd4;
  localparam logic [3:0] c_ST_EXEC     = 4'd5;
  localparam logic [3:0] c_ST_WAIT_ARM = 4'd6;
  localparam logic [3:0] c_ST_WAIT_RUN = 4'd7;
  localparam logic [3:0] c_ST_HALT     = 4'd8;

  localparam logic [3:0] c_OP_NOP   = 4'd0;
  localparam logic [3:0] c_OP_ADD   = 4'd1;
  localparam logic [3:0] c_OP_SUB   = 4'd2;
  localparam logic [3:0] c_OP_SETLO = 4'd3;
  localparam logic [3:0] c_OP_SETHI = 4'd4;
  localparam logic [3:0] c_OP_LDI   = 4'd5;
  localparam logic [3:0] c_OP_JMP   = 4'd6;
  localparam logic [3:0] c_OP_BZ    = 4'd7;
  localparam logic [3:0] c_OP_WAIT  = 4'd8;
  localparam logic [3:0] c_OP_HALT  = 4'd15;

  logic [3:0]  r_state;
  logic [3:0]  w_next_state;
  logic [15:0] r_ir;
  logic [7:0]  r_opa;
  logic [7:0]  r_opb;
  logic        r_illegal;

  logic [3:0]  w_op;
  logic [1:0]  w_rd;
  logic [1:0]  w_rs;
  logic [7:0]  w_imm;
  logic        w_is_alu;
  logic        w_uses_rd;
  logic        w_bad;

  assign w_op  = r_ir[15:12];
  assign w_rd  = r_ir[11:10];
  assign w_rs  = r_ir[9:8];
  assign w_imm = r_ir[7:0];

  assign w_is_alu  = (w_op == c_OP_ADD) || (w_op == c_OP_SUB) ||
                     (w_op == c_OP_SETLO) || (w_op == c_OP_SETHI);
  assign w_uses_rd = w_is_alu || (w_op == c_OP_LDI) || (w_op == c_OP_BZ);
  // Register index 3 does not exist; only fields the opcode actually reads count.
  assign w_bad = ((w_op >= 4'd9) && (w_op <= 4'd14)) ||
                 (w_uses_rd && (w_rd == 2'd3)) ||
                 (w_is_alu && (w_rs == 2'd3));

  assign instr_addr = pc;
  assign busy       = (r_state != c_ST_IDLE) && (r_state != c_ST_HALT);
  assign halted     = (r_state == c_ST_HALT);
  assign illegal    = r_illegal;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state   <= c_ST_IDLE;
      r_ir      <= 16'd0;
      r_opa     <= 8'd0;
      r_opb     <= 8'd0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == c_ST_FETCH)
        r_ir <= instr_data;
      if (r_state == c_ST_READ_A)
        r_opa <= rf_selected0;
      if (r_state == c_ST_READ_B)
        r_opb <= rf_selected0;
      if ((r_state == c_ST_DECODE) && w_bad)
        r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE:     if (start) w_next_state = c_ST_FETCH;
      c_ST_FETCH:    w_next_state = c_ST_DECODE;
      c_ST_DECODE: begin
        if (w_bad || (w_op == c_OP_HALT))
          w_next_state = c_ST_HALT;
        else if (w_is_alu || (w_op == c_OP_BZ))
          w_next_state = c_ST_READ_A;
        else
          w_next_state = c_ST_EXEC;
      end
      // BZ only needs rd, so it skips the second operand read.
      c_ST_READ_A:   w_next_state = (w_op == c_OP_BZ) ? c_ST_EXEC : c_ST_READ_B;
      c_ST_READ_B:   w_next_state = c_ST_EXEC;
      c_ST_EXEC:     w_next_state = (w_op == c_OP_WAIT) ? c_ST_WAIT_ARM : c_ST_FETCH;
      c_ST_WAIT_ARM: w_next_state = c_ST_WAIT_RUN;
      c_ST_WAIT_RUN: if (dly_done) w_next_state = c_ST_FETCH;
      c_ST_HALT:     w_next_state = c_ST_HALT;
      default:       w_next_state = c_ST_IDLE;
    endcase
  end

  always_comb begin
    pc_increment = 1'b0;
    pc_branch    = 1'b0;
    pc_newpc     = 8'd0;
    rf_select0   = 2'd0;
    rf_write     = 1'b0;
    rf_wr_select = 2'd0;
    rf_data      = 8'd0;
    alu_a        = 8'd0;
    alu_b        = 8'd0;
    alu_add_sub  = 1'b0;
    alu_set_low  = 1'b0;
    alu_set_high = 1'b0;
    dly_start    = 1'b0;
    dly_enable   = 1'b0;
    dly_value    = 8'd0;
    case (r_state)
      c_ST_DECODE: rf_select0 = w_rd;
      c_ST_READ_A: rf_select0 = w_rs;
      c_ST_EXEC: begin
        case (w_op)
          c_OP_ADD, c_OP_SUB, c_OP_SETLO, c_OP_SETHI: begin
            alu_a        = r_opa;
            alu_b        = r_opb;
            alu_add_sub  = (w_op == c_OP_SUB);
            alu_set_low  = (w_op == c_OP_SETLO);
            alu_set_high = (w_op == c_OP_SETHI);
            rf_write     = 1'b1;
            rf_wr_select = w_rd;
            rf_data      = alu_result;
            pc_increment = 1'b1;
          end
          c_OP_LDI: begin
            rf_write     = 1'b1;
            rf_wr_select = w_rd;
            rf_data      = w_imm;
            pc_increment = 1'b1;
          end
          c_OP_NOP: pc_increment = 1'b1;
          c_OP_JMP: begin
            pc_branch = 1'b1;
            pc_newpc  = w_imm;
          end
          c_OP_BZ: begin
            if (r_opa == 8'd0) begin
              pc_branch = 1'b1;
              pc_newpc  = w_imm;
            end else begin
              pc_increment = 1'b1;
            end
          end
          c_OP_WAIT: begin
            dly_start = 1'b1;
            dly_value = w_imm;
          end
          default: ;
        endcase
      end
      // dly_done may still be high from the previous delay; ignore it here.
      c_ST_WAIT_ARM: dly_enable = 1'b1;
      c_ST_WAIT_RUN: begin
        dly_enable   = 1'b1;
        pc_increment = dly_done;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_controller.sv
`default_nettype none
// Bench for seq_controller: surrounding PC/RF/ALU/delay/ROM models plus an
// instruction-level reference interpreter for programs built in each test.
module tb_seq_controller;

  logic        clock = 1'b0;
  logic        reset_n, start;
  logic [7:0]  pc;
  logic [7:0]  instr_addr;
  logic [15:0] instr_data;
  logic        pc_increment, pc_branch;
  logic [7:0]  pc_newpc;
  logic [1:0]  rf_select0;
  logic [7:0]  rf_selected0;
  logic        rf_write;
  logic [1:0]  rf_wr_select;
  logic [7:0]  rf_data, alu_a, alu_b, alu_result;
  logic        alu_add_sub, alu_set_low, alu_set_high;
  logic        dly_start, dly_enable, dly_done;
  logic [7:0]  dly_value;
  logic        busy, halted, illegal;

  always #5 clock = ~clock;

  seq_controller dut (
    .clock(clock), .reset_n(reset_n), .start(start), .pc(pc),
    .instr_addr(instr_addr), .instr_data(instr_data),
    .pc_increment(pc_increment), .pc_branch(pc_branch), .pc_newpc(pc_newpc),
    .rf_select0(rf_select0), .rf_selected0(rf_selected0), .rf_write(rf_write),
    .rf_wr_select(rf_wr_select), .rf_data(rf_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_add_sub(alu_add_sub),
    .alu_set_low(alu_set_low), .alu_set_high(alu_set_high), .alu_result(alu_result),
    .dly_start(dly_start), .dly_enable(dly_enable), .dly_value(dly_value),
    .dly_done(dly_done), .busy(busy), .halted(halted), .illegal(illegal)
  );

  // ---------------- environment models ----------------
  logic [15:0] rom [256];
  logic [7:0]  rf [3];
  logic        rf_clr;
  logic [7:0]  dcnt;
  logic        done_q;

  assign instr_data = rom[instr_addr];
  assign dly_done   = done_q;
  assign alu_result = alu_add_sub  ? alu_a - alu_b :
                      alu_set_low  ? {alu_a[7:4], alu_b[3:0]} :
                      alu_set_high ? {alu_b[7:4], alu_a[3:0]} : alu_a + alu_b;

  always @(posedge clock) begin
    if (!reset_n) pc <= 8'd0;
    else if (pc_branch) pc <= pc_newpc;
    else if (pc_increment) pc <= pc + 8'd1;
  end

  always @(posedge clock) begin
    if (rf_clr) begin
      rf[0] <= 8'd0; rf[1] <= 8'd0; rf[2] <= 8'd0;
    end else if (rf_write && rf_wr_select != 2'd3) begin
      rf[rf_wr_select] <= rf_data;
    end
    rf_selected0 <= (rf_select0 != 2'd3) ? rf[rf_select0] : 8'd0;
  end

  // Delay counter: done stays high after expiry, so it is stale on the next WAIT.
  always @(posedge clock) begin
    if (!reset_n) begin
      dcnt <= 8'd0; done_q <= 1'b1;
    end else if (dly_start) begin
      dcnt <= dly_value;
    end else if (dly_enable) begin
      if (dcnt != 8'd0) dcnt <= dcnt - 8'd1;
      done_q <= (dcnt <= 8'd1);
    end
  end

  // ---------------- activity monitor ----------------
  int n_wr, n_inc, n_br, n_proto, n_alu_bad;
  logic [9:0] a_wq [$];
  logic [7:0] a_bq [$];
  logic [54:0] all_out;
  assign all_out = {pc_increment, pc_branch, pc_newpc, rf_select0, rf_write, rf_wr_select,
                    rf_data, alu_a, alu_b, alu_add_sub, alu_set_low, alu_set_high,
                    dly_start, dly_enable, dly_value, busy, halted, illegal};

  always @(negedge clock) begin
    if (!reset_n) begin
      n_wr = 0; n_inc = 0; n_br = 0; n_proto = 0; n_alu_bad = 0;
      a_wq.delete(); a_bq.delete();
    end else begin
      if (rf_write) begin n_wr++; a_wq.push_back({rf_wr_select, rf_data}); end
      if (pc_increment) n_inc++;
      if (pc_branch) begin n_br++; a_bq.push_back(pc_newpc); end
      if ((pc_increment && pc_branch) || (instr_addr !== pc) || (!pc_branch && pc_newpc != 8'd0))
        n_proto++;
      if ((int'(alu_add_sub) + int'(alu_set_low) + int'(alu_set_high) > 1) ||
          ((alu_add_sub || alu_set_low || alu_set_high) && !rf_write))
        n_alu_bad++;
    end
  end

  // ---------------- reference interpreter ----------------
  int m_cyc, m_inc, m_br, meas_cyc;
  logic [7:0] m_pc;
  logic [7:0] m_rf [3];
  logic m_ill;
  logic [9:0] m_wq [$];
  logic [7:0] m_bq [$];
  int total = 0, bad = 0;

  function automatic logic [15:0] enc(input int op, input int rd, input int rs, input int imm);
    logic [3:0] o; logic [1:0] d, s; logic [7:0] i;
    o = op[3:0]; d = rd[1:0]; s = rs[1:0]; i = imm[7:0];
    return {o, d, s, i};
  endfunction

  task automatic model_run();
    logic [7:0] p, a, b, res, imm;
    logic [3:0] op;
    logic [1:0] rd, rs;
    p = 8'd0; m_cyc = 0; m_inc = 0; m_br = 0; m_ill = 1'b0;
    for (int k = 0; k < 3; k++) m_rf[k] = 8'd0;
    m_wq.delete(); m_bq.delete();
    for (int step = 0; step < 1000; step++) begin
      {op, rd, rs, imm} = rom[p];
      if ((op >= 4'd9 && op <= 4'd14) ||
          (((op >= 4'd1 && op <= 4'd5) || op == 4'd7) && rd == 2'd3) ||
          ((op >= 4'd1 && op <= 4'd4) && rs == 2'd3)) begin
        m_ill = 1'b1; m_cyc += 2; break;
      end
      if (op == 4'd15) begin m_cyc += 2; break; end
      case (op)
        4'd1, 4'd2, 4'd3, 4'd4: begin
          a = m_rf[rd]; b = m_rf[rs];
          res = (op == 4'd1) ? a + b : (op == 4'd2) ? a - b :
                (op == 4'd3) ? {a[7:4], b[3:0]} : {b[7:4], a[3:0]};
          m_rf[rd] = res; m_wq.push_back({rd, res});
          m_cyc += 5; m_inc++; p++;
        end
        4'd5: begin m_rf[rd] = imm; m_wq.push_back({rd, imm}); m_cyc += 3; m_inc++; p++; end
        4'd6: begin m_bq.push_back(imm); m_br++; p = imm; m_cyc += 3; end
        4'd7: begin
          m_cyc += 4;
          if (m_rf[rd] == 8'd0) begin m_bq.push_back(imm); m_br++; p = imm; end
          else begin m_inc++; p++; end
        end
        4'd8: begin m_cyc += 4 + int'(imm); m_inc++; p++; end
        default: begin m_cyc += 3; m_inc++; p++; end
      endcase
    end
    m_pc = p;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; start = 1'b0; rf_clr = 1'b1;
    repeat (2) @(negedge clock);
    reset_n = 1'b1; rf_clr = 1'b0;
    @(negedge clock);
  endtask

  // Cycle k after start is sampled at the k-th negedge; HALT shows one cycle after the HALT op decodes.
  task automatic run_prog();
    model_run();
    do_reset();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    meas_cyc = -1;
    for (int k = 1; k <= 3000; k++) begin
      if (halted) begin meas_cyc = k - 1; break; end
      @(negedge clock);
    end
    repeat (2) @(negedge clock);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    repeat (3) @(negedge clock);
    total++; if (all_out !== 55'd0) begin bad++; $display("FAIL reset_outputs got=%h want=0", all_out); end
    total++; if (instr_addr !== pc) begin bad++; $display("FAIL reset_addr got=%h want=%h", instr_addr, pc); end
  endtask

  task automatic test_ldi_add();
    clear_rom();
    rom[0] = enc(5, 0, 0, 8'h12); rom[1] = enc(5, 1, 0, 8'h34); rom[2] = enc(1, 0, 1, 0);
    run_prog();
    total++; if (rf[0] !== 8'h46) begin bad++; $display("FAIL add_r0 got=%h want=46", rf[0]); end
    total++; if (pc !== 8'd3) begin bad++; $display("FAIL add_pc got=%h want=3", pc); end
    total++; if (meas_cyc !== 13) begin bad++; $display("FAIL add_cycles got=%0d want=13", meas_cyc); end
    total++; if (n_wr !== 3) begin bad++; $display("FAIL add_writes got=%0d want=3", n_wr); end
  endtask

  task automatic test_alu_ops();
    logic [7:0] exp_v [3];
    exp_v[0] = 8'h69; exp_v[1] = 8'hAC; exp_v[2] = 8'h35;
    clear_rom();
    rom[0] = enc(5, 0, 0, 8'hA5); rom[1] = enc(5, 1, 0, 8'h3C); rom[2] = enc(2, 0, 1, 0);
    rom[3] = enc(5, 0, 0, 8'hA5); rom[4] = enc(3, 0, 1, 0);
    rom[5] = enc(5, 0, 0, 8'hA5); rom[6] = enc(4, 0, 1, 0);
    run_prog();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (a_wq.size() < 7 || a_wq[2 + 2 * i] !== {2'd0, exp_v[i]}) begin
        bad++; $display("FAIL alu_op%0d got=%h want=%h", i, (a_wq.size() < 7) ? 10'h3FF : a_wq[2 + 2 * i], {2'd0, exp_v[i]});
      end
    end
    total++; if (n_alu_bad !== 0) begin bad++; $display("FAIL alu_ctrl_onehot got=%0d want=0", n_alu_bad); end
    total++; if (meas_cyc !== m_cyc) begin bad++; $display("FAIL alu_cycles got=%0d want=%0d", meas_cyc, m_cyc); end
  endtask

  task automatic test_branch();
    clear_rom();
    rom[0] = enc(5, 2, 0, 0); rom[1] = enc(7, 2, 0, 8'h20);
    rom[8'h20] = enc(5, 2, 0, 1); rom[8'h21] = enc(7, 2, 0, 8'h30); rom[8'h22] = enc(6, 0, 0, 8'h05);
    run_prog();
    total++; if (a_bq.size() !== 2) begin bad++; $display("FAIL br_count got=%0d want=2", a_bq.size()); end
    total++; if (a_bq.size() < 1 || a_bq[0] !== 8'h20) begin bad++; $display("FAIL bz_target got=%h want=20", (a_bq.size() < 1) ? 8'hXX : a_bq[0]); end
    total++; if (n_inc !== 3) begin bad++; $display("FAIL br_incs got=%0d want=3", n_inc); end
    total++; if (pc !== 8'h05) begin bad++; $display("FAIL jmp_pc got=%h want=05", pc); end
    total++; if (meas_cyc !== 19) begin bad++; $display("FAIL br_cycles got=%0d want=19", meas_cyc); end
    total++; if (n_proto !== 0) begin bad++; $display("FAIL br_protocol got=%0d want=0", n_proto); end
  endtask

  task automatic test_wait();
    clear_rom();
    rom[0] = enc(8, 0, 0, 3);
    run_prog();
    total++; if (meas_cyc !== 9) begin bad++; $display("FAIL wait_cycles got=%0d want=9", meas_cyc); end
    total++; if (n_inc !== 1 || pc !== 8'd1) begin bad++; $display("FAIL wait_inc got=%0d/%h want=1/01", n_inc, pc); end
  endtask

  task automatic test_illegal();
    clear_rom();
    rom[0] = 16'hB000;
    run_prog();
    total++; if ({halted, illegal} !== 2'b11) begin bad++; $display("FAIL ill_flags got=%b want=11", {halted, illegal}); end
    total++; if (n_wr + n_inc + n_br !== 0) begin bad++; $display("FAIL ill_pulses got=%0d want=0", n_wr + n_inc + n_br); end
    start = 1'b1; @(negedge clock); start = 1'b0; repeat (4) @(negedge clock);
    total++; if ({halted, busy} !== 2'b10) begin bad++; $display("FAIL ill_start_ignored got=%b want=10", {halted, busy}); end
    do_reset();
    total++; if ({halted, illegal} !== 2'b00) begin bad++; $display("FAIL ill_reset got=%b want=00", {halted, illegal}); end
    rom[0] = enc(5, 3, 0, 8'h77);
    run_prog();
    total++; if ({illegal, n_wr[0]} !== 2'b10 || n_wr !== 0) begin bad++; $display("FAIL ldi_r3 got=%b/%0d want=1/0", illegal, n_wr); end
  endtask

  task automatic test_reset_mid();
    clear_rom();
    rom[0] = enc(5, 0, 0, 1); rom[1] = enc(1, 0, 0, 0);
    do_reset();
    start = 1'b1; @(negedge clock); start = 1'b0;
    repeat (6) @(negedge clock);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b want=1", busy); end
    reset_n = 1'b0; @(negedge clock);
    total++; if (all_out !== 55'd0) begin bad++; $display("FAIL mid_outputs got=%h want=0", all_out); end
    reset_n = 1'b1; repeat (3) @(negedge clock);
    total++; if (rf[0] !== 8'd1) begin bad++; $display("FAIL mid_no_write got=%h want=01", rf[0]); end
  endtask

  task automatic test_random();
    int len, op, imm;
    for (int t = 0; t < 5; t++) begin
      clear_rom();
      len = 14;
      for (int i = 0; i < len; i++) begin
        op = $urandom_range(0, 8);
        imm = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255);
        if (op == 6 || op == 7) imm = i + 1 + $urandom_range(0, 2);
        if (op == 8) imm = $urandom_range(1, 4);
        rom[i] = enc(op, $urandom_range(0, 2), $urandom_range(0, 2), imm);
      end
      run_prog();
      total++; if (meas_cyc !== m_cyc) begin bad++; $display("FAIL rnd%0d_cycles got=%0d want=%0d", t, meas_cyc, m_cyc); end
      total++; if (pc !== m_pc) begin bad++; $display("FAIL rnd%0d_pc got=%h want=%h", t, pc, m_pc); end
      for (int k = 0; k < 3; k++) begin
        total++; if (rf[k] !== m_rf[k]) begin bad++; $display("FAIL rnd%0d_r%0d got=%h want=%h", t, k, rf[k], m_rf[k]); end
      end
      total++; if (a_wq != m_wq) begin bad++; $display("FAIL rnd%0d_writes got=%0d want=%0d entries/values", t, a_wq.size(), m_wq.size()); end
      total++; if (a_bq != m_bq || n_inc !== m_inc) begin bad++; $display("FAIL rnd%0d_pcflow got=%0d/%0d want=%0d/%0d", t, n_br, n_inc, m_br, m_inc); end
      total++; if (n_proto + n_alu_bad !== 0 || illegal !== m_ill) begin bad++; $display("FAIL rnd%0d_protocol got=%0d/%b want=0/%b", t, n_proto + n_alu_bad, illegal, m_ill); end
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; rf_clr = 1'b1;
    clear_rom();
    test_reset();
    test_ldi_add();
    test_alu_ops();
    test_branch();
    test_wait();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
